// File: rtl/serial_add_engine.sv
// serial_add_engine: bit-serial adder datapath and controller.
// Drives load/shift-enable of two upstream LSB-first shift registers.
// Adds one bit pair per cycle through a full adder and a carry flop.
// Deserialises the sum and presents it with a valid/ack handshake.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start_i             request an addition (sampled in IDLE only)
//   bit_a_i, bit_b_i    serial operand bits from the upstream shift registers
//   load_o, shift_en_o  parallel-load strobe / shift-enable to the upstream registers
//   busy_o              high while loading or adding
//   valid_o, ack_i      result handshake (ack sampled in DONE only)
//   sum_o, cout_o       parallel sum (bit0 = LSB) and final carry out
module serial_add_engine #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             bit_a_i,
   input  logic             bit_b_i,
   output logic             load_o,
   output logic             shift_en_o,
   output logic             busy_o,
   output logic             valid_o,
   input  logic             ack_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ADD  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sum_sr;
   logic               sum_bit_c;
   logic               carry_nxt_c;
   logic               last_c;

   // Full adder on the current bit pair
   assign sum_bit_c   = bit_a_i ^ bit_b_i ^ carry;
   assign carry_nxt_c = (bit_a_i & bit_b_i) | (bit_a_i & carry) | (bit_b_i & carry);
   assign last_c      = (cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_i) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_ADD;
         ST_ADD:  if (last_c) state_nxt = ST_DONE;
         ST_DONE: if (ack_i) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobes registered from the next state so they line up with the state they describe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_o     <= 1'b0;
         shift_en_o <= 1'b0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
      end else begin
         load_o     <= (state_nxt == ST_LOAD);
         shift_en_o <= (state_nxt == ST_ADD);
         busy_o     <= (state_nxt == ST_LOAD) || (state_nxt == ST_ADD);
         valid_o    <= (state_nxt == ST_DONE);
      end
   end

   // Serial datapath; carry is cleared in LOAD so nothing leaks between operations
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry  <= 1'b0;
         cnt    <= '0;
         sum_sr <= '0;
         sum_o  <= '0;
         cout_o <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               carry  <= 1'b0;
               cnt    <= '0;
               sum_sr <= '0;
            end
            ST_ADD: begin
               carry  <= carry_nxt_c;
               sum_sr <= {sum_bit_c, sum_sr[WIDTH-1:1]};
               cnt    <= cnt + CNT_W'(1);
               if (last_c) begin
                  sum_o  <= {sum_bit_c, sum_sr[WIDTH-1:1]};
                  cout_o <= carry_nxt_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_engine.sv
module tb_serial_add_engine;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             bit_a_i;
   logic             bit_b_i;
   logic             load_o;
   logic             shift_en_o;
   logic             busy_o;
   logic             valid_o;
   logic             ack_i;
   logic [WIDTH-1:0] sum_o;
   logic             cout_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Upstream operand shift registers (LSB-first)
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0] sr_a, sr_b;
   int load_cnt, shift_cnt;

   serial_add_engine #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .bit_a_i(bit_a_i), .bit_b_i(bit_b_i),
      .load_o(load_o), .shift_en_o(shift_en_o), .busy_o(busy_o),
      .valid_o(valid_o), .ack_i(ack_i), .sum_o(sum_o), .cout_o(cout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_o) begin
         sr_a <= op_a;
         sr_b <= op_b;
      end else if (shift_en_o) begin
         sr_a <= sr_a >> 1;
         sr_b <= sr_b >> 1;
      end
   end
   assign bit_a_i = sr_a[0];
   assign bit_b_i = sr_b[0];

   always @(negedge clk) begin
      if (load_o)     load_cnt++;
      if (shift_en_o) shift_cnt++;
   end

   // Pulse start for one cycle with the given operands; returns at the negedge after the sampling edge
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      op_a = a;
      op_b = b;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Wait for valid_o, counting sampling edges after the start edge (bounded)
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      lat = lat - 1;
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; ack_i = 1'b0;
      op_a = '0; op_b = '0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({load_o, shift_en_o, busy_o, valid_o, cout_o, sum_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ld=%b sh=%b busy=%b v=%b c=%b sum=%h, want all 0",
                  load_o, shift_en_o, busy_o, valid_o, cout_o, sum_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat;
      load_cnt = 0; shift_cnt = 0;
      start_op(8'h5A, 8'h33);
      n_tests++;
      if (load_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_load: load=%b busy=%b, want 1 1", load_o, busy_o);
      end
      wait_valid(lat);
      n_tests++;
      if (lat !== 9) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d, want 9", lat);
      end
      n_tests++;
      if (load_cnt !== 1 || shift_cnt !== 8) begin
         n_fail++;
         $display("FAIL basic_strobes: loads=%0d shifts=%0d, want 1 8", load_cnt, shift_cnt);
      end
      n_tests++;
      if (sum_o !== 8'h8D || cout_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_sum: sum=%h c=%b busy=%b, want 8d 0 0", sum_o, cout_o, busy_o);
      end
      do_ack();
   endtask

   task automatic test_back_to_back();
      int lat;
      start_op(8'hFF, 8'h01);
      wait_valid(lat);
      n_tests++;
      if (sum_o !== 8'h00 || cout_o !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: sum=%h c=%b, want 00 1", sum_o, cout_o);
      end
      do_ack();
      start_op(8'h00, 8'h00);
      wait_valid(lat);
      n_tests++;
      if (sum_o !== 8'h00 || cout_o !== 1'b0 || lat !== 9) begin
         n_fail++;
         $display("FAIL carry_cleared: sum=%h c=%b lat=%0d, want 00 0 9", sum_o, cout_o, lat);
      end
      do_ack();
   endtask

   task automatic test_hold_ack();
      int lat;
      int bad;
      start_op(8'hFF, 8'hFF);
      wait_valid(lat);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b1 || sum_o !== 8'hFE || cout_o !== 1'b1) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL hold_valid: %0d bad cycles, last v=%b sum=%h c=%b, want v=1 fe 1",
                  bad, valid_o, sum_o, cout_o);
      end
      do_ack();
      n_tests++;
      if (valid_o !== 1'b0 || sum_o !== 8'hFE || cout_o !== 1'b1) begin
         n_fail++;
         $display("FAIL after_ack: v=%b sum=%h c=%b, want 0 fe 1", valid_o, sum_o, cout_o);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      load_cnt = 0;
      start_op(8'h01, 8'h02);
      repeat (3) @(negedge clk);
      start_i = 1'b1;               // mid-ADD start must be ignored
      @(negedge clk);
      start_i = 1'b0;
      wait_valid(lat);
      @(negedge clk);
      ack_i = 1'b1;                 // ack and start together in DONE: start dropped
      start_i = 1'b1;
      @(negedge clk);
      ack_i = 1'b0;
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (load_cnt !== 1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start: loads=%0d v=%b busy=%b, want 1 0 0", load_cnt, valid_o, busy_o);
      end
      n_tests++;
      if (sum_o !== 8'h03 || cout_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start_sum: sum=%h c=%b, want 03 0", sum_o, cout_o);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      start_op(8'h12, 8'h34);       // now in LOAD cycle
      repeat (4) @(negedge clk);    // now in 4th ADD cycle
      rst = 1'b1;
      #1;
      n_tests++;
      if ({load_o, shift_en_o, busy_o, valid_o, cout_o, sum_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: ld=%b sh=%b busy=%b v=%b c=%b sum=%h, want all 0",
                  load_o, shift_en_o, busy_o, valid_o, cout_o, sum_o);
      end
      @(negedge clk);
      rst = 1'b0;
      start_op(8'h12, 8'h34);
      wait_valid(lat);
      n_tests++;
      if (sum_o !== 8'h46 || cout_o !== 1'b0 || lat !== 9) begin
         n_fail++;
         $display("FAIL after_reset: sum=%h c=%b lat=%0d, want 46 0 9", sum_o, cout_o, lat);
      end
      do_ack();
   endtask

   task automatic test_random();
      int lat;
      logic [WIDTH-1:0] a, b;
      logic [WIDTH:0]   exp;
      for (int i = 0; i < 200; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         exp = (WIDTH+1)'(a) + (WIDTH+1)'(b);
         start_op(a, b);
         wait_valid(lat);
         n_tests++;
         if ({cout_o, sum_o} !== exp || lat !== 9) begin
            n_fail++;
            $display("FAIL random[%0d]: a=%h b=%h got %h lat=%0d, want %h lat=9",
                     i, a, b, {cout_o, sum_o}, lat, exp);
         end
         do_ack();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hold_ack();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
